// File: rtl/rv_arb_pkg.sv
// Shared definitions for the round-robin ready/valid arbiter.
package rv_arb_pkg;

  localparam int MAX_REQ = 16;

  // Source tag width; a two-requester arbiter still needs one bit.
  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rv_rr_arbiter_if.sv
// Bundle of the requester-side and consumer-side ready/valid signals.
interface rv_rr_arbiter_if
  import rv_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int SRC_WIDTH = src_width(NUM_REQ);

  // Handshake: a word moves on a port when valid and ready are both high at a
  // rising edge; valid never waits for ready and holds with stable data until taken.
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]            in_valid;
  logic [NUM_REQ-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [SRC_WIDTH-1:0]          out_src;
  logic                          out_valid;
  logic                          out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin winner search starting just after the last grant.
module rr_pick
  import rv_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [src_width(NUM_REQ)-1:0]   last,
  output logic [src_width(NUM_REQ)-1:0]   gnt_idx,
  output logic                            gnt_any
);
  localparam int SRC_WIDTH = src_width(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   base;
  int                   offset;

  always_comb begin
    base    = (int'(last) + 1) % NUM_REQ;
    // Rotating the doubled vector puts candidate last+1 at bit 0.
    dbl     = {req, req} >> base;
    rot     = dbl[NUM_REQ-1:0];
    offset  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = k;
    end
    gnt_any = |req;
    gnt_idx = SRC_WIDTH'((base + offset) % NUM_REQ);
  end

endmodule

// File: rtl/rv_rr_arbiter.sv
// Round-robin arbiter: NUM_REQ ready/valid producers into one registered,
// source-tagged ready/valid output with full one-per-cycle throughput.
module rv_rr_arbiter
  import rv_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  rv_rr_arbiter_if.slave bus
);
  localparam int SRC_WIDTH = src_width(NUM_REQ);

  logic [SRC_WIDTH-1:0]  last_grant;
  logic [SRC_WIDTH-1:0]  gnt_idx;
  logic                  gnt_any;
  logic                  load;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SRC_WIDTH-1:0]  out_src_q;
  logic [DATA_WIDTH-1:0] win_data;
  logic [NUM_REQ-1:0]    rdy;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.in_valid),
    .last    (last_grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // The output slot can take a word when empty or when being drained this edge.
  assign load = !out_valid_q || bus.out_ready;

  always_comb begin
    win_data = '0;
    rdy      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == SRC_WIDTH'(i)) begin
        win_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        rdy[i]   = load && gnt_any && !rst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      last_grant  <= SRC_WIDTH'(NUM_REQ - 1);
    end else if (load) begin
      if (gnt_any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= win_data;
        out_src_q   <= gnt_idx;
        last_grant  <= gnt_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Bench for rv_rr_arbiter: directed scenarios plus protocol-legal random traffic,
// every cycle compared against a modular-search reference of the arbitration rules.
module tb_rv_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  rv_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int          m_last;
  bit          m_valid;
  logic [7:0]  m_data;
  int          m_src;

  logic [DW-1:0] pdata [N];
  bit            pend  [N];

  task automatic model_reset();
    m_last  = N - 1;
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic rdy);
    bus.in_valid  = v;
    bus.out_ready = rdy;
    for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = pdata[i];
  endtask

  // One clock: check outputs and in_ready mid-cycle, then advance the model at the edge.
  task automatic cycle(output int acc);
    int            w;
    bit            ld;
    logic [N-1:0]  er;
    @(negedge clk);
    #1;
    ld = !m_valid || bus.out_ready;
    w  = winner(bus.in_valid);
    er = '0;
    if (!rst && ld && w >= 0) er[w] = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'(er));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    check("out_src", 32'(bus.out_src), 32'(m_src));
    @(posedge clk);
    #1;
    acc = -1;
    if (rst) begin
      model_reset();
    end else if (ld) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = bus.in_data[w*DW +: DW];
        m_src   = w;
        m_last  = w;
        acc     = w;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int acc;
    model_reset();
    for (int i = 0; i < N; i++) begin
      pdata[i] = '0;
      pend[i]  = 1'b0;
    end

    // Reset: in_ready held low even with every requester valid.
    drive('1, 1'b1);
    cycle(acc);
    cycle(acc);
    rst = 1'b0;

    // All four valid: strict rotation 0,1,2,3,...
    for (int i = 0; i < N; i++) pdata[i] = 8'h10 + 8'(i);
    drive(4'b1111, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle(acc);
      check("rot_src", 32'(bus.out_src), 32'(k % 4));
      check("rot_data", 32'(bus.out_data), 32'(8'h10 + 8'(k % 4)));
    end

    // Requesters 1 and 3 only, starting after a grant to 3.
    drive(4'b1010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(acc);
      check("pair_src", 32'(bus.out_src), (k % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Backpressure: hold 0xA5 for five cycles, then drain and refill in one edge.
    pdata[0] = 8'hA5;
    drive(4'b0001, 1'b1);
    cycle(acc);
    check("bp_load", 32'(bus.out_data), 32'hA5);
    pdata[1] = 8'h5A;
    drive(4'b0010, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(acc);
      check("bp_hold", 32'(bus.out_data), 32'hA5);
    end
    drive(4'b0010, 1'b1);
    cycle(acc);
    check("bp_refill", 32'(bus.out_data), 32'h5A);
    check("bp_refill_src", 32'(bus.out_src), 32'd1);

    // Single requester 2 wins back to back with no bubbles.
    for (int k = 0; k < 6; k++) begin
      pdata[2] = 8'h20 + 8'(k);
      drive(4'b0100, 1'b1);
      cycle(acc);
      check("solo_data", 32'(bus.out_data), 32'(8'h20 + 8'(k)));
      check("solo_src", 32'(bus.out_src), 32'd2);
      check("solo_valid", 32'(bus.out_valid), 32'd1);
    end

    // Idle: output drains, pointer stays at 2 so requester 3 is next.
    drive(4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(acc);
      check("idle_valid", 32'(bus.out_valid), 32'd0);
    end
    for (int i = 0; i < N; i++) pdata[i] = 8'h30 + 8'(i);
    drive(4'b1111, 1'b1);
    cycle(acc);
    check("idle_ptr", 32'(bus.out_src), 32'd3);
    cycle(acc);

    // Asynchronous reset mid-cycle while holding a word.
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_data", 32'(bus.out_data), 32'd0);
    check("arst_src", 32'(bus.out_src), 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd0);
    cycle(acc);
    rst = 1'b0;
    cycle(acc);
    check("arst_first", 32'(bus.out_src), 32'd0);
    check("arst_first_data", 32'(bus.out_data), 32'h30);

    // Random traffic obeying the hold-until-accepted rule.
    drive(4'b0000, 1'b1);
    cycle(acc);
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          pdata[i] = DW'($urandom_range(0, 255));
        end
        v[i] = pend[i];
      end
      drive(v, $urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc >= 0) pend[acc] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
